// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display path: FSM states,
// seven-segment codes and the decimal range helper.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low codes, index = BCD digit, bit 0 = segment a
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };

  function automatic logic [31:0] max_decimal(input int unsigned digits);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/score_display_ctrl_seg7.sv
// Combinational BCD digit to active-low seven-segment encoder with blank input.
import score_display_pkg::*;

module seg7_encode (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (digit_i <= 4'd9)) begin
      seg_o = SEG_TABLE[digit_i];
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: double-dabble binary-to-BCD conversion with a
// load/busy handshake, display latch, leading-zero blanking and blink.
import score_display_pkg::*;

module score_display_ctrl #(
  parameter int unsigned BIN_W     = 16,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   hex_seg
);

  localparam int unsigned BW      = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [31:0] MAX_VAL = max_decimal(DIGITS);

  state_e              state_q, state_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                big_q, big_d;
  logic [BW-1:0]       disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                phase_q, phase_d;
  logic [DIGITS-1:0]   dig_blank;
  logic                nz;
  logic [7*DIGITS-1:0] seg_d, hex_seg_q;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    big_d   = big_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    bcd_adj = bcd_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          big_d   = ({32'd0, value} > {{BIN_W{1'b0}}, MAX_VAL});
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        done    = 1'b1;
        disp_d  = big_q ? {DIGITS{4'd9}} : bcd_q;
        ovf_d   = big_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_cnt_d = '0;
    phase_d   = 1'b0;
    if (blink_en) begin
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
        phase_d   = phase_q;
      end
    end
  end

  // Encode from the next display value so new digits appear the cycle after done
  always_comb begin
    nz        = 1'b0;
    dig_blank = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (disp_d[4*(DIGITS-1-k) +: 4] != 4'd0) begin
        nz = 1'b1;
      end
      dig_blank[DIGITS-1-k] = (blink_en && phase_q) ||
                              (blank_lz && (k != DIGITS-1) && !nz);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_encode u_enc (
      .digit_i (disp_d[4*g +: 4]),
      .blank_i (dig_blank[g]),
      .seg_o   (seg_d[7*g +: 7])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      big_q     <= 1'b0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      hex_seg_q <= '1;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      big_q     <= big_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      hex_seg_q <= seg_d;
    end
  end

  assign ovf     = ovf_q;
  assign hex_seg = hex_seg_q;

endmodule
